// File: rtl/axis_pkt_gen.sv
// AXI-Stream packet generator: emits a counted or continuous run of packets
// with an incrementing payload from seed, an optional inter-packet gap, and a graceful stop.
module axis_pkt_gen #(
  parameter int unsigned DW    = 8,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [15:0]      num_pkts,
  input  logic [LEN_W-1:0] pkt_len,
  input  logic [LEN_W-1:0] gap,
  input  logic [DW-1:0]    seed,
  output logic [DW-1:0]    m_tdata,
  output logic             m_tvalid,
  output logic             m_tlast,
  input  logic             m_tready,
  output logic             busy,
  output logic             done,
  output logic [15:0]      pkt_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [15:0]      num_q, num_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] gap_q, gap_d;
  logic [DW-1:0]    seed_q, seed_d;
  logic [LEN_W-1:0] beat_q, beat_d;
  logic [LEN_W-1:0] gcnt_q, gcnt_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             stop_q, stop_d;
  logic [DW-1:0]    tdata_q, tdata_d;
  logic             tvalid_q, tvalid_d;
  logic             tlast_q, tlast_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic xfer;
  logic stop_now;
  logic last_beat;
  logic run_end;

  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    len_d    = len_q;
    gap_d    = gap_q;
    seed_d   = seed_q;
    beat_d   = beat_q;
    gcnt_d   = gcnt_q;
    cnt_d    = cnt_q;
    stop_d   = stop_q;

    xfer      = tvalid_q & m_tready;
    stop_now  = stop_q | stop;
    last_beat = (beat_q == len_q - LEN_W'(1));
    run_end   = (num_q != '0) && (({1'b0, cnt_q} + 17'd1) == {1'b0, num_q});

    case (state_q)
      S_IDLE: begin
        stop_d = 1'b0;
        if (start) begin
          num_d   = num_pkts;
          len_d   = (pkt_len == '0) ? LEN_W'(1) : pkt_len;
          gap_d   = gap;
          seed_d  = seed;
          beat_d  = '0;
          cnt_d   = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        stop_d = stop_now;
        if (xfer) begin
          if (last_beat) begin
            beat_d = '0;
            if (cnt_q != '1) cnt_d = cnt_q + 16'd1;
            if (run_end || stop_now) begin
              state_d = S_DONE;
            end else if (gap_q != '0) begin
              state_d = S_GAP;
              gcnt_d  = gap_q - LEN_W'(1);
            end
          end else begin
            beat_d = beat_q + LEN_W'(1);
          end
        end
      end
      S_GAP: begin
        stop_d = stop_now;
        if (gcnt_q == '0) begin
          state_d = stop_now ? S_DONE : S_SEND;
        end else begin
          gcnt_d = gcnt_q - LEN_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next-state view so the beat stays stable while stalled.
    tvalid_d = (state_d == S_SEND);
    tdata_d  = (state_d == S_SEND) ? seed_d + DW'(beat_d) : '0;
    tlast_d  = (state_d == S_SEND) && (beat_d == len_d - LEN_W'(1));
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      num_q    <= '0;
      len_q    <= '0;
      gap_q    <= '0;
      seed_q   <= '0;
      beat_q   <= '0;
      gcnt_q   <= '0;
      cnt_q    <= '0;
      stop_q   <= 1'b0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      len_q    <= len_d;
      gap_q    <= gap_d;
      seed_q   <= seed_d;
      beat_q   <= beat_d;
      gcnt_q   <= gcnt_d;
      cnt_q    <= cnt_d;
      stop_q   <= stop_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign m_tdata   = tdata_q;
  assign m_tvalid  = tvalid_q;
  assign m_tlast   = tlast_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pkt_count = cnt_q;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Scoreboard bench for axis_pkt_gen: expected beats are queued at stimulus time
// and matched against every presented beat on the falling edge.
module tb_axis_pkt_gen;
  localparam int DW    = 8;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [15:0]      num_pkts = '0;
  logic [LEN_W-1:0] pkt_len = '0;
  logic [LEN_W-1:0] gap = '0;
  logic [DW-1:0]    seed = '0;
  logic [DW-1:0]    m_tdata;
  logic             m_tvalid;
  logic             m_tlast;
  logic             m_tready = 1'b1;
  logic             busy;
  logic             done;
  logic [15:0]      pkt_count;

  axis_pkt_gen #(.DW(DW), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .num_pkts(num_pkts), .pkt_len(pkt_len), .gap(gap), .seed(seed),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .busy(busy), .done(done), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [8:0] exp_q[$];
  bit mon_en = 1'b0;
  int xfer_n = 0;
  int last_edge = 0;
  int exp_gap = 0;
  bit in_gap = 1'b0;
  int gap_run = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (in_gap) begin
        if (m_tvalid) begin
          check_eq("gap_len", gap_run, exp_gap);
          in_gap = 1'b0;
        end else if (done) begin
          in_gap = 1'b0;
        end else begin
          gap_run++;
        end
      end
      if (m_tvalid) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_beat", 1, 0);
        end else begin
          check_eq("tdata", m_tdata, exp_q[0][7:0]);
          check_eq("tlast", m_tlast, exp_q[0][8]);
          if (m_tready) begin
            void'(exp_q.pop_front());
            xfer_n++;
            if (m_tlast) begin
              last_edge = cyc + 1;
              in_gap = 1'b1;
              gap_run = 0;
            end
          end
        end
      end
    end
  end

  task automatic push_pkts(input int npk, input int len, input logic [7:0] sd);
    int eff;
    logic [7:0] d;
    eff = (len == 0) ? 1 : len;
    for (int p = 0; p < npk; p++) begin
      for (int b = 0; b < eff; b++) begin
        d = 8'(int'(sd) + b);
        exp_q.push_back({(b == eff - 1), d});
      end
    end
  endtask

  task automatic start_run(input int num, input int len, input int g, input logic [7:0] sd);
    @(posedge clk); #1;
    num_pkts = 16'(num);
    pkt_len  = LEN_W'(len);
    gap      = LEN_W'(g);
    seed     = sd;
    xfer_n   = 0;
    in_gap   = 1'b0;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("busy_after_start", busy, 1);
    check_eq("tvalid_after_start", m_tvalid, 1);
  endtask

  task automatic wait_done(input bit bp, input bit chk_lat, input int exp_cnt);
    int n;
    int hold;
    bit held;
    n = 0;
    hold = 0;
    held = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (done) break;
      n++;
      if (n > 3000) begin
        check_eq("done_timeout", 0, 1);
        break;
      end
      if (bp) begin
        if (hold > 0) begin
          m_tready = 1'b0;
          hold--;
        end else if (!held && m_tvalid && m_tlast) begin
          held = 1'b1;
          m_tready = 1'b0;
          hold = 4;
        end else begin
          m_tready = 1'($urandom_range(0, 1));
        end
      end
    end
    m_tready = 1'b1;
    if (done) begin
      check_eq("pkt_count_at_done", pkt_count, exp_cnt);
      if (chk_lat) check_eq("done_latency", cyc, last_edge);
    end
    check_eq("sb_empty", exp_q.size(), 0);
    @(posedge clk); #1;
    check_eq("busy_after_done", busy, 0);
    check_eq("done_one_cycle", done, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tvalid", m_tvalid, 0);
    check_eq("rst_tlast", m_tlast, 0);
    check_eq("rst_tdata", m_tdata, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_pkt_count", pkt_count, 0);
    rst = 1'b0;
    mon_en = 1'b1;

    // single run, back-to-back packets
    push_pkts(2, 4, 8'h10); exp_gap = 0;
    start_run(2, 4, 0, 8'h10);
    wait_done(1'b0, 1'b1, 2);

    // gap insertion
    push_pkts(3, 3, 8'h00); exp_gap = 2;
    start_run(3, 3, 2, 8'h00);
    wait_done(1'b0, 1'b1, 3);

    // backpressure, same traffic as the first run
    push_pkts(2, 4, 8'h10); exp_gap = 0;
    start_run(2, 4, 0, 8'h10);
    wait_done(1'b1, 1'b1, 2);

    // zero length means one beat
    push_pkts(3, 0, 8'h33); exp_gap = 0;
    start_run(3, 0, 0, 8'h33);
    wait_done(1'b0, 1'b1, 3);

    // payload wrap
    push_pkts(1, 4, 8'hFE);
    start_run(1, 4, 0, 8'hFE);
    wait_done(1'b0, 1'b1, 1);

    // continuous mode, stop during beat 2 of the third packet
    push_pkts(3, 5, 8'h00); exp_gap = 0;
    start_run(0, 5, 0, 8'h00);
    for (int n = 0; n < 200 && xfer_n != 12; n++) begin
      @(posedge clk); #1;
    end
    check_eq("stop_point", xfer_n, 12);
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    wait_done(1'b0, 1'b1, 3);

    // continuous mode, stop while in the gap
    push_pkts(1, 2, 8'h40); exp_gap = 4;
    start_run(0, 2, 4, 8'h40);
    for (int n = 0; n < 200 && xfer_n != 2; n++) begin
      @(posedge clk); #1;
    end
    check_eq("in_gap_tvalid", m_tvalid, 0);
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    wait_done(1'b0, 1'b0, 1);

    // start while busy is ignored and input changes do not leak into the run
    push_pkts(2, 3, 8'h20); exp_gap = 1;
    start_run(2, 3, 1, 8'h20);
    @(posedge clk); #1;
    num_pkts = 16'd5;
    pkt_len  = 8'd6;
    gap      = 8'd0;
    seed     = 8'h99;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1'b0, 1'b1, 2);

    // reset in the middle of the second packet
    mon_en = 1'b0;
    start_run(3, 4, 0, 8'h55);
    repeat (5) begin
      @(posedge clk); #1;
    end
    check_eq("pre_rst_pkt_count", pkt_count, 1);
    check_eq("pre_rst_tdata", m_tdata, 8'h56);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("midrst_tvalid", m_tvalid, 0);
    check_eq("midrst_tlast", m_tlast, 0);
    check_eq("midrst_tdata", m_tdata, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_done", done, 0);
    check_eq("midrst_pkt_count", pkt_count, 0);
    rst = 1'b0;
    exp_q.delete();

    // clean run after reset
    mon_en = 1'b1;
    push_pkts(1, 2, 8'h70); exp_gap = 0;
    start_run(1, 2, 0, 8'h70);
    wait_done(1'b0, 1'b1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_pkt_gen.md
# axis_pkt_gen

Upstream AXI-Stream traffic source feeding the AXI register-slice stage. On command it emits a configurable number of packets, each of configurable length, with a deterministic incrementing payload and an optional idle gap between packets. Used as the stimulus front end for stream datapath bring-up and loopback checking.

## Interface

**Parameters**
- `DW`, default 8: data width.
- `LEN_W`, default 8: width of the packet-length and gap fields.

**Ports**
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `start`, in, 1: single-cycle command. Honoured only in IDLE.
- `stop`, in, 1: graceful stop request. Honoured in SEND and GAP.
- `num_pkts`, in, 16: packets per run. 0 means continuous until `stop`.
- `pkt_len`, in, LEN_W: beats per packet. 0 is treated as 1.
- `gap`, in, LEN_W: idle cycles between packets.
- `seed`, in, DW: payload value of beat 0 of every packet.
- `m_tdata`, out, DW: stream data.
- `m_tvalid`, out, 1: stream valid.
- `m_tlast`, out, 1: last beat of packet.
- `m_tready`, in, 1: downstream ready.
- `busy`, out, 1: high in any state other than IDLE.
- `done`, out, 1: one-cycle pulse when a run ends.
- `pkt_count`, out, 16: packets completed in the current or last run.

## Operation

**Configuration capture**
- `num_pkts`, `pkt_len`, `gap` and `seed` are latched on an accepted `start`.
- Input changes during a run have no effect.

**States**
- IDLE
  - `start` → SEND.
  - Clears `pkt_count` and the beat index.
- SEND
  - `m_tvalid`=1.
  - `m_tdata` = `seed` + beat_idx, mod 2^DW.
  - `m_tlast`=1 when beat_idx = effective_len−1.
  - A transfer occurs when `m_tvalid` and `m_tready` are both 1. beat_idx increments on each transfer.
  - On the last-beat transfer:
    - `pkt_count` increments and beat_idx returns to 0.
    - If the run is finished (`pkt_count`+1 = `num_pkts` with `num_pkts`≠0, or `stop` is pending) → DONE.
    - Otherwise, if `gap`=0 → stay in SEND.
    - Otherwise → GAP.
- GAP
  - `m_tvalid`=0. Counts `gap` cycles.
  - At the end of the count → SEND. If `stop` is pending → DONE instead.
- DONE
  - Asserts `done` for one cycle, then → IDLE.

**Stop behaviour**
- `stop` sets a sticky pending flag that is cleared in IDLE.
- A packet already started is always completed; it is never truncated.
- A `stop` asserted on the same cycle as a last-beat transfer ends the run after that packet.

**AXI-Stream rules**
- Once `m_tvalid` rises, `m_tvalid`, `m_tdata` and `m_tlast` hold stable until the transfer.
- `m_tvalid` never depends combinationally on `m_tready`. All outputs are registered.

**Counters**
- `pkt_count` saturates at 0xFFFF, but the run continues in continuous mode.
- Payload wraps modulo 2^DW within a packet.

## Timing

**Reset values**
- `m_tvalid`=0, `m_tlast`=0, `m_tdata`=0, `busy`=0, `done`=0, `pkt_count`=0.
- State = IDLE and the stop-pending flag is cleared.

**Latency**
- `start` sampled at edge N → `busy`=1 and `m_tvalid`=1 after edge N.
- First beat is presented in cycle N+1.

**Back-to-back behaviour**
- With `gap`=0 and `m_tready`=1, packets are back-to-back: one beat per cycle with no bubble.
- With `gap`=G, there are exactly G cycles of `m_tvalid`=0 between the last beat of one packet and the first beat of the next.

**End of run**
- `done` asserts in the cycle after the final last-beat transfer.
- `busy` drops in the cycle after `done`.

**Reset mid-run**
- Reset aborts immediately with reset values.
- A partial packet is acceptable in this case only.

## Test plan

1. **Single run, no gap.** `num_pkts`=2, `pkt_len`=4, `gap`=0, `seed`=0x10, `m_tready`=1.
   - Required: 8 consecutive beats with data 10,11,12,13,10,11,12,13.
   - `m_tlast` on beats 3 and 7.
   - `done` one cycle after beat 7; `pkt_count`=2.
2. **Gap insertion.** `pkt_len`=3, `gap`=2, `num_pkts`=3.
   - Required: exactly 2 `m_tvalid`=0 cycles between packets.
   - 9 beats total; `done` after the ninth.
3. **Backpressure.** Toggle `m_tready` pseudo-randomly, including holding it low for 5 cycles during a `m_tlast` beat.
   - Required: data and `m_tlast` stable while stalled; no beats lost or duplicated.
   - Sequence identical to scenario 1.
4. **Edge lengths.**
   - `pkt_len`=0 → every beat has `m_tlast`=1 and data = `seed`.
   - `seed`=0xFE, `pkt_len`=4 → data FE,FF,00,01.
5. **Continuous mode with stop.** `num_pkts`=0, `pkt_len`=5. Pulse `stop` during beat 2 of packet 3.
   - Required: packet 3 completes, `pkt_count`=3, then `done`.
   - `stop` during GAP ends the run without starting the next packet.
6. **Reset and ignored start.**
   - `rst` asserted mid-packet → all outputs at reset values next cycle.
   - `start` pulsed while `busy` → ignored; the run configuration is unchanged.
